esm_issue_select: RTL and testbench
===================================

Name: esm_issue_select

Overview:
- Issue stage directly downstream of the ESM dependency-analysis core.
- Holds up to bs in-flight instruction slots, each with a dependency row (bit j set = waits on slot j), as produced by the IRT/IDT stage.
- Each cycle selects one slot whose dependencies are all resolved, using round-robin fairness, and presents its index on a valid/ready issue port.
- Completion reports free slots and clear the matching dependency column in every row.

Parameters:
- bs, 16, number of instruction buffer slots (power of two, >=2).
- IW, $clog2(bs), slot index width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- alloc_valid  in  1  new instruction written into slot alloc_index this cycle.
- alloc_index  in  IW  target slot.
- alloc_dep  in  bs  dependency row for the new instruction.
- alloc_err  out  1  registered one-cycle pulse: alloc targeted a non-FREE slot.
- issue_valid  out  1  issue_index holds a selected instruction.
- issue_index  out  IW  selected slot.
- issue_ready  in  1  downstream accepts issue_index this cycle.
- complete_valid  in  1  slot complete_index finished execution.
- complete_index  in  IW  completing slot.
- occupancy  out  IW+1  count of non-FREE slots.

Behaviour:
- Slot states: FREE, WAITING, ISSUED (2-bit per slot). State is held in bs-entry arrays plus a bs×bs dependency matrix DEP.
- Reset (synchronous, active-high, overrides all inputs that cycle):
  - All slots FREE; DEP all 0; rr_ptr 0.
  - issue_valid 0, issue_index 0, alloc_err 0, occupancy 0.
  - Reset asserted mid-operation discards all slots and any pending issue.
- Alloc:
  - Accepted only if the slot is FREE. Slot becomes WAITING.
  - Stored row = alloc_dep AND (slots non-FREE) AND NOT(own bit) AND NOT(completing bit this cycle).
  - If the slot is not FREE: slot unchanged, alloc_err=1 next cycle.
- Ready: slot is WAITING and its DEP row is 0, evaluated from registered state only.
- Output register:
  - Loads when !issue_valid || issue_ready.
  - If a ready slot exists at load time: the first ready slot at or after rr_ptr (wrapping mod bs) is loaded, issue_valid=1, that slot goes WAITING→ISSUED in the same edge, and rr_ptr ← selected+1 mod bs.
  - If no ready slot exists at load time: issue_valid←0 and issue_index is held.
  - While issue_valid && !issue_ready: issue_index stable and no new selection.
- Latency:
  - Alloc with zero deps sampled at edge E0 → issue_valid=1 after edge E1.
  - Completion sampled at E0 clears the column at E0 → a dependent becomes ready after E0 → issued after E1 (if the output register is free).
- Completion:
  - Accepted only if the slot is ISSUED: slot→FREE and column complete_index cleared in all rows.
  - Completion of a FREE or WAITING slot is ignored (no state change).
- Simultaneous events:
  - Alloc and completion of different slots in the same cycle are both applied.
  - Alloc targeting a slot that completes that same cycle → alloc_err (slot was not FREE when sampled).
- Occupancy: +1 per accepted alloc, −1 per accepted completion; both in one cycle → unchanged. Range 0..bs.
- A slot never depends on itself.
- bs simultaneous allocations cannot exceed capacity because the index is externally chosen.

Decomposition:
- Package esm_pkg holds:
  - slot-state enum (FREE=0, WAITING=1, ISSUED=2);
  - shared constants (default bs, regnum);
  - index-width helper.
- One sub-module: esm_rr_picker, a combinational rotating priority encoder. Inputs: req[bs], start ptr. Outputs: grant_valid, grant_index.

Test Plan:
1. Reset → issue_valid=0, issue_index=0, occupancy=0, alloc_err=0. Hold rst for 2 cycles with alloc_valid=1 → still empty.
2. Alloc slot 0, dep=0, at E0, issue_ready=1 → issue_valid=1, issue_index=0 after E1. Complete 0 → occupancy returns 0.
3. Alloc slot 1 (dep 0) and slot 2 (dep bit1) → slot 1 issues, slot 2 not issued. Complete 1 at E5 → slot 2 issued after E6.
4. issue_ready=0 for 5 cycles with slots 3 and 4 ready → issue_index stays 3 and slot 4 stays WAITING. Raise ready → next index 4.
5. Slots 3, 5, 7 ready with rr_ptr=6 → issue order 7, 3, 5.
6. Alloc to WAITING slot 5 → alloc_err pulses one cycle, DEP row unchanged. Complete on WAITING slot 5 → ignored, occupancy unchanged. Assert rst while slots are ISSUED → all FREE next cycle.

Source files
------------

// File: rtl/esm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : esm_pkg
// Brief    : Shared slot-state encoding, constants and width helper for the
//            ESM issue-select slice.
// Revision : 1.0
// ============================================================================
package esm_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WAITING = 2'd1,
    ISSUED  = 2'd2
  } slot_state_t;

  localparam int c_default_bs = 16;
  localparam int c_regnum     = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/esm_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : esm_rr_picker
// Brief    : Combinational rotating priority encoder; grants the first
//            requester at or after i_start, wrapping modulo N.
// Revision : 1.0
// ============================================================================
module esm_rr_picker
  import esm_pkg::*;
#(
  parameter int N  = c_default_bs,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic          o_grant_valid,
  output logic [IW-1:0] o_grant_index
);

  // Scan from the far end so the closest requester to i_start is written last.
  // N is a power of two, so the IW-bit sum wraps modulo N for free.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[i_start + IW'(k)]) begin
        o_grant_valid = 1'b1;
        o_grant_index = i_start + IW'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/esm_issue_select.sv
`default_nettype none
// ============================================================================
// Module   : esm_issue_select
// Brief    : Slot buffer with dependency matrix; issues one ready slot per
//            cycle round-robin on a valid/ready port, retires on completion.
// Revision : 1.0
// ============================================================================
module esm_issue_select
  import esm_pkg::*;
#(
  parameter int bs = c_default_bs,
  parameter int IW = idx_w(bs)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_valid,
  input  logic [IW-1:0] alloc_index,
  input  logic [bs-1:0] alloc_dep,
  output logic          alloc_err,
  output logic          issue_valid,
  output logic [IW-1:0] issue_index,
  input  logic          issue_ready,
  input  logic          complete_valid,
  input  logic [IW-1:0] complete_index,
  output logic [IW:0]   occupancy
);

  slot_state_t   r_state [bs];
  logic [bs-1:0] r_dep   [bs];
  logic [IW-1:0] r_rr_ptr;
  logic          r_issue_valid;
  logic [IW-1:0] r_issue_index;
  logic          r_alloc_err;
  logic [IW:0]   r_occ;

  logic [bs-1:0] w_ready;
  logic [bs-1:0] w_nonfree;
  logic [bs-1:0] w_cmpl_mask;
  logic [bs-1:0] w_own_mask;
  logic [bs-1:0] w_alloc_row;
  logic          w_alloc_ok;
  logic          w_cmpl_ok;
  logic          w_load;
  logic          w_grant_valid;
  logic [IW-1:0] w_grant_index;
  logic          w_issue_fire;

  always_comb begin
    w_ready   = '0;
    w_nonfree = '0;
    for (int i = 0; i < bs; i++) begin
      w_ready[i]   = (r_state[i] == WAITING) && (r_dep[i] == '0);
      w_nonfree[i] = (r_state[i] != FREE);
    end
  end

  assign w_alloc_ok = alloc_valid && (r_state[alloc_index] == FREE);
  assign w_cmpl_ok  = complete_valid && (r_state[complete_index] == ISSUED);

  always_comb begin
    w_cmpl_mask                 = '0;
    w_cmpl_mask[complete_index] = w_cmpl_ok;
    w_own_mask                  = '0;
    w_own_mask[alloc_index]     = 1'b1;
  end

  // Only live producers are recorded; one retiring this cycle is already done.
  assign w_alloc_row = alloc_dep & w_nonfree & ~w_own_mask & ~w_cmpl_mask;

  assign w_load       = !r_issue_valid || issue_ready;
  assign w_issue_fire = w_load && w_grant_valid;

  esm_rr_picker #(
    .N  (bs),
    .IW (IW)
  ) u_picker (
    .i_req         (w_ready),
    .i_start       (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_index (w_grant_index)
  );

  // Accepted alloc (FREE), completion (ISSUED) and issue (WAITING) can never
  // name the same slot, so the per-slot priority below never drops an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < bs; i++) begin
        r_state[i] <= FREE;
        r_dep[i]   <= '0;
      end
      r_rr_ptr      <= '0;
      r_issue_valid <= 1'b0;
      r_issue_index <= '0;
      r_alloc_err   <= 1'b0;
      r_occ         <= '0;
    end else begin
      for (int i = 0; i < bs; i++) begin
        if (w_cmpl_ok && (complete_index == IW'(i))) begin
          r_state[i] <= FREE;
          r_dep[i]   <= '0;
        end else if (w_alloc_ok && (alloc_index == IW'(i))) begin
          r_state[i] <= WAITING;
          r_dep[i]   <= w_alloc_row;
        end else begin
          if (w_issue_fire && (w_grant_index == IW'(i))) begin
            r_state[i] <= ISSUED;
          end
          r_dep[i] <= r_dep[i] & ~w_cmpl_mask;
        end
      end

      if (w_load) begin
        r_issue_valid <= w_grant_valid;
        if (w_grant_valid) begin
          r_issue_index <= w_grant_index;
          r_rr_ptr      <= w_grant_index + IW'(1);
        end
      end

      r_alloc_err <= alloc_valid && !w_alloc_ok;
      r_occ       <= r_occ + (IW+1)'(w_alloc_ok) - (IW+1)'(w_cmpl_ok);
    end
  end

  assign alloc_err   = r_alloc_err;
  assign issue_valid = r_issue_valid;
  assign issue_index = r_issue_index;
  assign occupancy   = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_esm_issue_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_esm_issue_select
// Brief    : Self-checking bench: per-cycle vector table plus issue-order
//            scoreboard for esm_issue_select.
// Revision : 1.0
// ============================================================================
module tb_esm_issue_select;

  localparam int c_bs = 16;
  localparam int c_iw = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_valid;
  logic [c_iw-1:0] alloc_index;
  logic [c_bs-1:0] alloc_dep;
  logic            alloc_err;
  logic            issue_valid;
  logic [c_iw-1:0] issue_index;
  logic            issue_ready;
  logic            complete_valid;
  logic [c_iw-1:0] complete_index;
  logic [c_iw:0]   occupancy;

  int checks   = 0;
  int failures = 0;
  int sb[$];

  always #5 clk = ~clk;

  esm_issue_select #(.bs(c_bs)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_index    (alloc_index),
    .alloc_dep      (alloc_dep),
    .alloc_err      (alloc_err),
    .issue_valid    (issue_valid),
    .issue_index    (issue_index),
    .issue_ready    (issue_ready),
    .complete_valid (complete_valid),
    .complete_index (complete_index),
    .occupancy      (occupancy)
  );

  typedef struct {
    logic            rst;
    logic            av;
    logic [c_iw-1:0] ai;
    logic [c_bs-1:0] ad;
    logic            rdy;
    logic            cv;
    logic [c_iw-1:0] ci;
    int              push;
    logic            ev;
    logic [c_iw-1:0] ei;
    logic [c_iw:0]   eo;
    logic            ee;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic av, input int ai,
                               input logic [c_bs-1:0] ad, input logic rdy,
                               input logic cv, input int ci, input int push,
                               input logic ev, input int ei, input int eo,
                               input logic ee);
    vec_t v;
    v.rst = r;  v.av = av;  v.ai = c_iw'(ai);  v.ad = ad;  v.rdy = rdy;
    v.cv = cv;  v.ci = c_iw'(ci);  v.push = push;
    v.ev = ev;  v.ei = c_iw'(ei);  v.eo = (c_iw+1)'(eo);  v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle, then check registered outputs #1 after the edge.
  task automatic apply(input vec_t v, input string tag);
    rst            = v.rst;
    alloc_valid    = v.av;
    alloc_index    = v.ai;
    alloc_dep      = v.ad;
    issue_ready    = v.rdy;
    complete_valid = v.cv;
    complete_index = v.ci;
    if (v.push >= 0) sb.push_back(v.push);
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, int'(issue_valid), int'(v.ev));
    chk({tag, ".index"}, int'(issue_index), int'(v.ei));
    chk({tag, ".occ"},   int'(occupancy),   int'(v.eo));
    chk({tag, ".err"},   int'(alloc_err),   int'(v.ee));
  endtask

  task automatic run(input logic r, input logic av, input int ai,
                     input logic [c_bs-1:0] ad, input logic rdy, input logic cv,
                     input int ci, input int push, input logic ev, input int ei,
                     input int eo, input logic ee, input string tag);
    apply(mkv(r, av, ai, ad, rdy, cv, ci, push, ev, ei, eo, ee), tag);
  endtask

  // Handshake observed mid-cycle is consumed at the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && issue_valid === 1'b1 && issue_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb.unexpected actual=%0d expected=none", issue_index);
      end else begin
        int e;
        e = sb.pop_front();
        if (int'(issue_index) != e) begin
          failures++;
          $display("FAIL sb.order actual=%0d expected=%0d", issue_index, e);
        end
      end
    end
  end

  initial begin
    vec_t tbl[13];
    rst = 1'b1; alloc_valid = 1'b0; alloc_index = '0; alloc_dep = '0;
    issue_ready = 1'b0; complete_valid = 1'b0; complete_index = '0;

    // reset with alloc held high, single issue, dependency chain
    tbl[0]  = mkv(1, 1, 0, 16'h0000, 1, 0, 0, -1, 0, 0, 0, 0);
    tbl[1]  = mkv(1, 1, 0, 16'h0000, 1, 0, 0, -1, 0, 0, 0, 0);
    tbl[2]  = mkv(0, 0, 0, 16'h0000, 1, 0, 0, -1, 0, 0, 0, 0);
    tbl[3]  = mkv(0, 1, 0, 16'h0000, 1, 0, 0,  0, 0, 0, 1, 0);
    tbl[4]  = mkv(0, 0, 0, 16'h0000, 1, 0, 0, -1, 1, 0, 1, 0);
    tbl[5]  = mkv(0, 0, 0, 16'h0000, 1, 1, 0, -1, 0, 0, 0, 0);
    tbl[6]  = mkv(0, 1, 1, 16'h0000, 1, 0, 0,  1, 0, 0, 1, 0);
    tbl[7]  = mkv(0, 1, 2, 16'h0002, 1, 0, 0, -1, 1, 1, 2, 0);
    tbl[8]  = mkv(0, 0, 0, 16'h0000, 1, 0, 0, -1, 0, 1, 2, 0);
    tbl[9]  = mkv(0, 0, 0, 16'h0000, 1, 0, 0, -1, 0, 1, 2, 0);
    tbl[10] = mkv(0, 0, 0, 16'h0000, 1, 1, 1,  2, 0, 1, 1, 0);
    tbl[11] = mkv(0, 0, 0, 16'h0000, 1, 0, 0, -1, 1, 2, 1, 0);
    tbl[12] = mkv(0, 0, 0, 16'h0000, 1, 1, 2, -1, 0, 2, 0, 0);
    for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // stall: index held while downstream refuses
    run(0, 1, 3, 16'h0, 0, 0, 0,  3, 0, 2, 1, 0, "stall_a");
    run(0, 1, 4, 16'h0, 0, 0, 0,  4, 1, 3, 2, 0, "stall_b");
    for (int i = 0; i < 5; i++)
      run(0, 0, 0, 16'h0, 0, 0, 0, -1, 1, 3, 2, 0, $sformatf("hold%0d", i));
    run(0, 0, 0, 16'h0, 1, 0, 0, -1, 1, 4, 2, 0, "stall_rel");
    run(0, 0, 0, 16'h0, 1, 0, 0, -1, 0, 4, 2, 0, "stall_drain");
    run(0, 0, 0, 16'h0, 1, 1, 3, -1, 0, 4, 1, 0, "cmpl3");
    run(0, 0, 0, 16'h0, 1, 1, 4, -1, 0, 4, 0, 0, "cmpl4");

    // round-robin wrap: steer rr_ptr to 6, then release 3,5,7 together
    run(0, 1, 0, 16'h0, 1, 0, 0,  0, 0, 4, 1, 0, "rr_a0");
    run(0, 1, 5, 16'h0, 1, 0, 0,  5, 1, 0, 2, 0, "rr_a5");
    run(0, 0, 0, 16'h0, 1, 0, 0, -1, 1, 5, 2, 0, "rr_i5");
    run(0, 0, 0, 16'h0, 1, 1, 5, -1, 0, 5, 1, 0, "rr_c5");
    sb.push_back(7); sb.push_back(3); sb.push_back(5);
    run(0, 1, 3, 16'h0001, 1, 0, 0, -1, 0, 5, 2, 0, "rr_w3");
    run(0, 1, 5, 16'h0001, 1, 0, 0, -1, 0, 5, 3, 0, "rr_w5");
    run(0, 1, 7, 16'h0001, 1, 0, 0, -1, 0, 5, 4, 0, "rr_w7");
    run(0, 0, 0, 16'h0,    1, 1, 0, -1, 0, 5, 3, 0, "rr_c0");
    run(0, 0, 0, 16'h0,    1, 0, 0, -1, 1, 7, 3, 0, "rr_1st");
    run(0, 0, 0, 16'h0,    1, 0, 0, -1, 1, 3, 3, 0, "rr_2nd");
    run(0, 0, 0, 16'h0,    1, 0, 0, -1, 1, 5, 3, 0, "rr_3rd");
    run(0, 0, 0, 16'h0,    1, 0, 0, -1, 0, 5, 3, 0, "rr_idle");

    // alloc errors, ignored completion, same-cycle events, reset flush
    run(0, 0, 0, 16'h0,    1, 1, 5, -1, 0, 5, 2, 0, "e_c5");
    run(0, 1, 5, 16'h0008, 1, 0, 0, -1, 0, 5, 3, 0, "e_w5");
    run(0, 1, 5, 16'h0000, 1, 0, 0, -1, 0, 5, 3, 1, "e_err");
    run(0, 0, 0, 16'h0,    1, 0, 0, -1, 0, 5, 3, 0, "e_pulse");
    run(0, 0, 0, 16'h0,    1, 1, 5, -1, 0, 5, 3, 0, "e_cwait");
    run(0, 1, 9, 16'h0080, 1, 1, 7,  9, 0, 5, 3, 0, "e_same");
    run(0, 0, 0, 16'h0,    1, 0, 0, -1, 1, 9, 3, 0, "e_i9");
    run(0, 1, 9, 16'h0,    1, 1, 9, -1, 0, 9, 2, 1, "e_acmp");
    run(0, 0, 0, 16'h0,    1, 1, 3,  5, 0, 9, 1, 0, "e_c3");
    run(0, 0, 0, 16'h0,    1, 0, 0, -1, 1, 5, 1, 0, "e_i5");
    run(0, 0, 0, 16'h0,    1, 0, 0, -1, 0, 5, 1, 0, "e_drain");
    run(1, 1, 2, 16'h0,    1, 0, 0, -1, 0, 0, 0, 0, "rst_mid");
    run(0, 0, 0, 16'h0,    1, 1, 5, -1, 0, 0, 0, 0, "rst_cfree");
    run(0, 1, 6, 16'h0,    1, 0, 0,  6, 0, 0, 1, 0, "rst_a6");
    run(0, 0, 0, 16'h0,    1, 0, 0, -1, 1, 6, 1, 0, "rst_i6");
    run(0, 0, 0, 16'h0,    1, 1, 6, -1, 0, 6, 0, 0, "rst_c6");

    chk("sb.leftover", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
